// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the demux1_3_stream block.
//   dest_e  - 2-bit destination code carried on in_sel
//   state_e - packet-level FSM state (awaiting first beat / forwarding / dropping)
//   NUM_CH  - number of output channels
package demux_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    DEST_A   = 2'b00,
    DEST_B   = 2'b01,
    DEST_C   = 2'b10,
    DEST_INV = 2'b11
  } dest_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/out_slot.sv
// out_slot: one-entry output register slice for a single demux channel.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   wr_en             - load wr_data/wr_last this cycle (caller only asserts when free)
//   wr_data, wr_last  - beat payload to load
//   valid, ready      - downstream handshake; data/last stay stable while valid & !ready
//   data, last        - registered beat payload
//   free              - slot can accept a write this cycle (empty, or draining now)
module out_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         wr_last,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         last,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  // A full slot that is being drained this cycle can be refilled in the same cycle.
  assign free = ~valid_q | ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
      last_d  = wr_last;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/demux1_3_stream.sv
// demux1_3_stream: registered 1-to-3 valid/ready stream demultiplexer.
// The destination (in_sel) is captured on the first beat of a packet and used
// for every following beat up to and including the in_last beat. Packets with
// destination 2'b11 are swallowed and counted in a saturating error counter.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid/in_ready          - input handshake
//   in_data, in_sel, in_last   - input beat, destination (first beat only), end of packet
//   out_valid/out_ready [2:0]  - per-channel handshake, bit0=a, bit1=b, bit2=c
//   out_data [3*W-1:0]         - channel k at [k*W +: W]
//   out_last [2:0]             - per-channel end of packet
//   err_cnt                    - dropped-packet count, saturating at all-ones
//   beat_cnt [47:0]            - only with DEMUX1_3_STATS_EN: per-channel 16-bit
//                                wrapping counts of delivered beats
module demux1_3_stream
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int ERR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_last,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [NUM_CH*W-1:0] out_data,
  output logic [NUM_CH-1:0]   out_last,
`ifdef DEMUX1_3_STATS_EN
  output logic [NUM_CH*16-1:0] beat_cnt,
`endif
  output logic [ERR_W-1:0]    err_cnt
);

  state_e             state_q, state_d;
  dest_e              dest_q, dest_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [NUM_CH-1:0]  slot_free;
  logic [NUM_CH-1:0]  wr_en;
  dest_e              wr_dest;
  logic               discard;
  logic               accept;
  logic               in_ready_c;

  function automatic logic free_of(input logic [NUM_CH-1:0] fr, input dest_e d);
    case (d)
      DEST_A:  free_of = fr[0];
      DEST_B:  free_of = fr[1];
      DEST_C:  free_of = fr[2];
      default: free_of = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    err_cnt_d  = err_cnt_q;
    wr_dest    = dest_q;
    discard    = 1'b0;
    in_ready_c = 1'b0;
    wr_en      = '0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        wr_dest = dest_e'(in_sel);
        if (wr_dest == DEST_INV) begin
          // Invalid destination: swallow the packet without backpressure.
          discard    = 1'b1;
          in_ready_c = 1'b1;
        end else begin
          in_ready_c = free_of(slot_free, wr_dest);
        end
      end
      FWD: begin
        in_ready_c = free_of(slot_free, dest_q);
      end
      DROP: begin
        discard    = 1'b1;
        in_ready_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = in_valid & in_ready_c;

    if (accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_en[k] = ~discard & (wr_dest == dest_e'(2'(k)));
      end
      // Only the first beat of a bad packet counts; DROP beats do not.
      if (state_q == IDLE && discard && err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = discard ? DROP : FWD;
        dest_d  = wr_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dest_q    <= DEST_A;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready = in_ready_c;
  assign err_cnt  = err_cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    out_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .wr_data (in_data),
      .wr_last (in_last),
      .valid   (out_valid[k]),
      .ready   (out_ready[k]),
      .data    (out_data[k*W +: W]),
      .last    (out_last[k]),
      .free    (slot_free[k])
    );
  end

`ifdef DEMUX1_3_STATS_EN
  logic [NUM_CH-1:0][15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (out_valid[k] & out_ready[k]) begin
        beat_cnt_d[k] = beat_cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  // Delivery counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_demux1_3_stream.sv
module tb_demux1_3_stream;

  localparam int W     = 8;
  localparam int ERR_W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_last;
  logic [2:0]    out_valid;
  logic [2:0]    out_ready;
  logic [3*W-1:0] out_data;
  logic [2:0]    out_last;
  logic [ERR_W-1:0] err_cnt;
`ifdef DEMUX1_3_STATS_EN
  logic [47:0]   beat_cnt;
`endif

  demux1_3_stream #(.W(W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef DEMUX1_3_STATS_EN
    .beat_cnt  (beat_cnt),
`endif
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-channel queues of expected {last,data}, plus packet state.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  bit m_first = 1'b1;
  bit m_drop  = 1'b0;
  int m_dest  = 0;
  int m_err   = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void qpush(input int k, input logic [8:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [8:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void model_reset();
    q0.delete(); q1.delete(); q2.delete();
    m_first = 1'b1;
    m_drop  = 1'b0;
    m_err   = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic [1:0] s, input logic l);
    if (m_first) begin
      if (s == 2'b11) begin
        m_drop = 1'b1;
        if (m_err < 255) m_err++;
      end else begin
        m_drop = 1'b0;
        m_dest = int'(s);
      end
    end
    if (!m_drop) qpush(m_dest, {l, d});
    m_first = l;
  endfunction

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  logic [8:0] hold_v[3];
  bit         hold_f[3];
  always @(negedge clk) begin
    logic [8:0] act;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) hold_f[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        act = {out_last[k], out_data[k*8 +: 8]};
        if (hold_f[k]) check($sformatf("stable_ch%0d", k), {out_valid[k], act}, {1'b1, hold_v[k]});
        if (out_valid[k] && out_ready[k]) begin
          if (qsize(k) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_ch%0d: got beat %0h, expected none at %0t", k, act, $time);
          end else begin
            check($sformatf("data_ch%0d", k), act, qpop(k));
          end
          hold_f[k] = 1'b0;
        end else if (out_valid[k]) begin
          hold_f[k] = 1'b1;
          hold_v[k] = act;
        end else begin
          hold_f[k] = 1'b0;
        end
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 3'($urandom);
    end
  end

  // Drives one beat starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic [1:0] s, input logic l, output int waited);
    bit will_drop;
    will_drop = m_first ? (s == 2'b11) : m_drop;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        $display("FAIL accept_timeout: got no in_ready, expected acceptance at %0t", $time);
        $fatal(1, "input handshake timed out");
      end
    end
    if (will_drop) check("drop_ready", waited, 0);
    model_accept(d, s, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int len;
    logic [1:0] s;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'b00;
    in_last   = 1'b0;
    out_ready = 3'b111;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_out_data",  out_data, 24'h0);
    check("rst_out_last",  out_last, 3'b000);
    check("rst_err_cnt",   err_cnt, 8'h00);
    check("rst_in_ready",  in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat packet to b
    send_beat(8'h5A, 2'b01, 1'b1, w);
    check("t1_valid", out_valid, 3'b010);
    check("t1_data",  out_data[15:8], 8'h5A);
    check("t1_last",  out_last, 3'b010);

    // Three-beat packet to c, in_sel changes after first beat
    send_beat(8'h11, 2'b10, 1'b0, w);
    send_beat(8'h22, 2'b00, 1'b0, w);
    send_beat(8'h33, 2'b00, 1'b1, w);
    check("t2_valid", out_valid, 3'b100);
    check("t2_data",  out_data[23:16], 8'h33);
    check("t2_last",  out_last[2], 1'b1);

    // Backpressure on a
    out_ready = 3'b110;
    send_beat(8'hA1, 2'b00, 1'b0, w);
    in_valid = 1'b1; in_data = 8'hA2; in_sel = 2'b00; in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready, 1'b0);
      check("t3_hold_valid",   out_valid[0], 1'b1);
      check("t3_hold_data",    out_data[7:0], 8'hA1);
    end
    @(posedge clk); #1;
    out_ready = 3'b111;
    send_beat(8'hA2, 2'b00, 1'b1, w);
    check("t3_second_wait", w, 0);
    check("t3_second_data", out_data[7:0], 8'hA2);

    // Back-to-back beats to a with continuous ready
    for (int i = 0; i < 4; i++) begin
      send_beat(8'hB0 + 8'(i), 2'b00, (i == 3), w);
      check("t4_b2b_wait", w, 0);
    end

    // Invalid destination packets, error counter saturation
    send_beat(8'hE0, 2'b11, 1'b0, w);
    send_beat(8'hE1, 2'b01, 1'b1, w);
    check("t5_err_one", err_cnt, 8'h01);
    for (int i = 0; i < 255; i++) send_beat(8'($urandom), 2'b11, 1'b1, w);
    @(negedge clk);
    check("t5_err_sat", err_cnt, 8'hFF);
    check("t5_err_model", err_cnt, m_err);
    check("t5_no_valid", out_valid, 3'b000);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a forwarded packet
    out_ready = 3'b000;
    send_beat(8'hC1, 2'b00, 1'b0, w);
    check("t6_pre_valid", out_valid, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 3'b000);
    check("t6_async_data",  out_data, 24'h0);
    check("t6_async_last",  out_last, 3'b000);
    check("t6_async_err",   err_cnt, 8'h00);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 3'b111;
    send_beat(8'hD1, 2'b00, 1'b1, w);
    check("t6_after_valid", out_valid, 3'b001);
    check("t6_after_data",  out_data[7:0], 8'hD1);

    // Randomized packets with random backpressure and input gaps
    rand_ready = 1'b1;
    for (int p = 0; p < 300; p++) begin
      s   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_beat(8'($urandom), (b == 0) ? s : 2'($urandom_range(0, 3)), (b == len - 1), w);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 3'b111;
    for (int i = 0; i < 20; i++) begin
      if (q0.size() + q1.size() + q2.size() == 0) break;
      @(posedge clk); #1;
    end
    check("rand_drained", q0.size() + q1.size() + q2.size(), 0);
    check("rand_err_cnt", err_cnt, m_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
